// File: rtl/vga_text_writer_pkg.sv
// Shared constants for the VGA text-buffer writer: geometry, widths, op encoding,
// blank code, colour codes and small address helpers.
package vga_text_writer_pkg;

  localparam int COLS   = 96;
  localparam int ROWS   = 32;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  localparam int CELLS      = COLS * ROWS;
  localparam int COPY_CELLS = (ROWS - 1) * COLS;

  localparam logic [DATA_W-1:0] BLANK_CH = DATA_W'(32);

  localparam logic [DATA_W-1:0] COLOR_BLACK       = DATA_W'(0);
  localparam logic [DATA_W-1:0] COLOR_PALETTE_MAX = DATA_W'(6);

  localparam logic [COL_W-1:0]  COL_MAX     = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX     = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CELLS_A     = ADDR_W'(CELLS);
  localparam logic [ADDR_W-1:0] COPY_BASE_A = ADDR_W'(COPY_CELLS);
  localparam logic [ADDR_W-1:0] COPY_LAST_A = ADDR_W'(COPY_CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);

  typedef enum logic [2:0] {
    OP_PUTC     = 3'd0,
    OP_NEWLINE  = 3'd1,
    OP_CLEAR    = 3'd2,
    OP_SETCUR   = 3'd3,
    OP_SETCOLOR = 3'd4
  } op_e;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * COLS_A + ADDR_W'(col);
  endfunction

  function automatic int unsigned clamp_max(input int unsigned v, input int unsigned hi);
    return (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/vga_text_writer_if.sv
// MMIO console command channel between the decoder (master) and the text writer (slave).
interface vga_text_writer_if;
  import vga_text_writer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [COL_W-1:0]  cmd_col;
  logic [ROW_W-1:0]  cmd_row;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_col, cmd_row,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_col, cmd_row,
    output cmd_ready
  );

endinterface

// File: rtl/vga_text_writer_cursor.sv
// Cursor position tracker: advance with line wrap, newline, clamped set, home, and a
// request flag raised when a wrap or newline would move past the last row.
module vga_text_writer_cursor
  import vga_text_writer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             nl_i,
  input  logic             set_i,
  input  logic             home_i,
  input  logic [COL_W-1:0] col_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             scroll_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    scroll_o = 1'b0;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (set_i) begin
      col_d = COL_W'(clamp_max(32'(col_i), COLS - 1));
      row_d = ROW_W'(clamp_max(32'(row_i), ROWS - 1));
    end else if (nl_i || (adv_i && col_q == COL_MAX)) begin
      // On the last row the row stays put; the screen scrolls underneath instead.
      col_d = '0;
      if (row_q == ROW_MAX) scroll_o = 1'b1;
      else                  row_d    = row_q + ROW_W'(1);
    end else if (adv_i) begin
      col_d = col_q + COL_W'(1);
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/vga_text_writer.sv
// Writer side of the VGA text buffer: executes console commands as text-RAM cell writes,
// including full-screen clear and a one-row hardware scroll using the RAM read port.
module vga_text_writer
  import vga_text_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  vga_text_writer_if.slave  cmd,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_ch,
  output logic [DATA_W-1:0] wr_color,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_ch,
  input  logic [DATA_W-1:0] rd_color,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SCROLL_CP,
    S_SCROLL_BLK
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_ch_q, wr_ch_d;
  logic [DATA_W-1:0] wr_color_q, wr_color_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              copy_q, copy_d;

  logic accept;
  logic cur_adv, cur_nl, cur_set, cur_home, cur_scroll;

  vga_text_writer_cursor u_cursor (
    .clk      (clk),
    .rst      (rst),
    .adv_i    (cur_adv),
    .nl_i     (cur_nl),
    .set_i    (cur_set),
    .home_i   (cur_home),
    .col_i    (cmd.cmd_col),
    .row_i    (cmd.cmd_row),
    .col_o    (cur_col),
    .row_o    (cur_row),
    .scroll_o (cur_scroll)
  );

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = ~cmd.cmd_ready;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      color_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_ch_q    <= '0;
      wr_color_q <= '0;
      rd_addr_q  <= '0;
      copy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_ch_q    <= wr_ch_d;
      wr_color_q <= wr_color_d;
      rd_addr_q  <= rd_addr_d;
      copy_q     <= copy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_ch_d    = wr_ch_q;
    wr_color_d = wr_color_q;
    rd_addr_d  = rd_addr_q;
    copy_d     = 1'b0;
    cur_adv    = 1'b0;
    cur_nl     = 1'b0;
    cur_set    = 1'b0;
    cur_home   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_PUTC: begin
              wr_en_d    = 1'b1;
              wr_addr_d  = cell_addr(cur_row, cur_col);
              wr_ch_d    = cmd.cmd_data;
              wr_color_d = color_q;
              cur_adv    = 1'b1;
            end
            OP_NEWLINE:  cur_nl  = 1'b1;
            OP_CLEAR: begin
              wr_en_d    = 1'b1;
              wr_addr_d  = '0;
              wr_ch_d    = BLANK_CH;
              wr_color_d = color_q;
              cnt_d      = ADDR_W'(1);
              state_d    = S_CLEAR;
            end
            OP_SETCUR:   cur_set = 1'b1;
            OP_SETCOLOR: color_d = cmd.cmd_data;
            default: ;
          endcase
          if (cur_scroll) begin
            cnt_d     = '0;
            rd_addr_d = COLS_A;
            state_d   = S_SCROLL_CP;
          end
        end
      end

      S_CLEAR: begin
        if (cnt_q == CELLS_A) begin
          cur_home = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = cnt_q;
          wr_ch_d    = BLANK_CH;
          wr_color_d = color_q;
          cnt_d      = cnt_q + ADDR_W'(1);
        end
      end

      // Read of cell COLS+k is issued in cycle k; its data is written to cell k in cycle k+1.
      S_SCROLL_CP: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        copy_d    = 1'b1;
        if (cnt_q == COPY_LAST_A) begin
          cnt_d   = '0;
          state_d = S_SCROLL_BLK;
        end else begin
          cnt_d     = cnt_q + ADDR_W'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end

      S_SCROLL_BLK: begin
        if (cnt_q == COLS_A) begin
          state_d = S_IDLE;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = COPY_BASE_A + cnt_q;
          wr_ch_d    = BLANK_CH;
          wr_color_d = color_q;
          cnt_d      = cnt_q + ADDR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Copy writes take the RAM read data directly so each copy lands one cycle after its read.
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_ch    = copy_q ? rd_ch    : wr_ch_q;
  assign wr_color = copy_q ? rd_color : wr_color_q;
  assign rd_addr  = rd_addr_q;

endmodule
